// File: rtl/udp_loop_fifo_ctrl_pkg.sv
// Shared definitions for the UDP loopback FIFO controller: default sizes,
// RX/TX state encodings and a saturating counter helper.
`timescale 1ns/1ps
package udp_loop_fifo_ctrl_pkg;

  localparam int DEF_FIFO_DEPTH  = 2048;
  localparam int DEF_LEN_W       = 12;
  localparam int DEF_LEN_Q_DEPTH = 4;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WRITE = 2'd1,
    R_DROP  = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_REQ  = 2'd1,
    T_SEND = 2'd2
  } tx_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/frame_len_queue.sv
// Small register FIFO holding the byte length of each frame stored in the
// payload FIFO; head is readable combinationally.
`timescale 1ns/1ps
module frame_len_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push && (count_r != CNT_FULL);
  assign pop_ok_s  = pop && (count_r != {(PTR_W + 1){1'b0}});

  // entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {W{1'b0}};
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // pointers and occupancy; push+pop together leaves count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == {(PTR_W + 1){1'b0}});

endmodule

// File: rtl/udp_loop_fifo_ctrl_chk.sv
// Simulation-only protocol checks on the payload FIFO handshake.
`timescale 1ns/1ps
module udp_loop_fifo_ctrl_chk (
  input logic clk,
  input logic rst_n,
  input logic fifo_wr_en,
  input logic fifo_full,
  input logic fifo_rd_en,
  input logic fifo_empty
);

  a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_wr_en && fifo_full));

  a_no_read_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_rd_en && fifo_empty));

endmodule

// File: rtl/udp_loop_fifo_ctrl.sv
// Frame-level admission and replay sequencing around the 2048x8 payload FIFO
// of the UDP loopback path.
`timescale 1ns/1ps
module udp_loop_fifo_ctrl
  import udp_loop_fifo_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int LEN_Q_DEPTH = DEF_LEN_Q_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx_start,
  input  logic [LEN_W-1:0]             rx_len,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  output logic                         fifo_wr_en,
  output logic [7:0]                   fifo_wr_data,
  input  logic                         fifo_full,
  output logic                         fifo_rd_en,
  input  logic                         fifo_empty,
  output logic                         tx_start_en,
  output logic [LEN_W-1:0]             tx_byte_num,
  input  logic                         tx_ack,
  input  logic                         tx_req,
  output logic [$clog2(LEN_Q_DEPTH):0] frame_pend,
  output logic [15:0]                  drop_cnt
);

  localparam int QC_W = $clog2(LEN_Q_DEPTH) + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(FIFO_DEPTH);

  rx_state_e        rx_state_r, rx_state_nxt_s;
  tx_state_e        tx_state_r, tx_state_nxt_s;
  logic [LEN_W-1:0] len_r, wr_cnt_r, fill_cnt_r, rd_cnt_r, tx_byte_num_r;
  logic [LEN_W-1:0] occ_s, free_s, q_head_s;
  logic [QC_W-1:0]  q_count_s, q_used_s;
  logic [15:0]      drop_cnt_r;
  logic [7:0]       fifo_wr_data_r;
  logic             fifo_wr_en_r, push_r, q_empty_s, pop_s, rd_en_s;
  logic             admit_s, last_byte_s, wr_byte_s, frame_done_s, drop_evt_s;

  // Count the byte still in the write register and the length still in
  // flight to the queue, so a frame announced right after another is judged
  // against what is really committed.
  assign occ_s       = fill_cnt_r + LEN_W'(fifo_wr_en_r);
  assign free_s      = DEPTH_L - occ_s;
  assign q_used_s    = q_count_s + QC_W'(push_r);
  assign admit_s     = (rx_len != {LEN_W{1'b0}}) && (rx_len <= free_s)
                       && (q_used_s < QC_W'(LEN_Q_DEPTH));
  assign last_byte_s = ((wr_cnt_r + LEN_W'(1)) == len_r);

  // RX next state and per-cycle strobes
  always_comb begin
    rx_state_nxt_s = rx_state_r;
    wr_byte_s      = 1'b0;
    frame_done_s   = 1'b0;
    drop_evt_s     = 1'b0;
    case (rx_state_r)
      R_IDLE: begin
        if (rx_start) begin
          if (admit_s) begin
            rx_state_nxt_s = R_WRITE;
          end else begin
            rx_state_nxt_s = R_DROP;
            drop_evt_s     = 1'b1;
          end
        end else begin
          rx_state_nxt_s = R_IDLE;
        end
      end
      R_WRITE: begin
        drop_evt_s = rx_start;
        wr_byte_s  = rx_valid;
        if (rx_valid && last_byte_s) begin
          rx_state_nxt_s = R_IDLE;
          frame_done_s   = 1'b1;
        end else begin
          rx_state_nxt_s = R_WRITE;
        end
      end
      R_DROP: begin
        if ((len_r == {LEN_W{1'b0}}) || (len_r > DEPTH_L)) begin
          rx_state_nxt_s = R_IDLE;
        end else if (rx_valid && last_byte_s) begin
          rx_state_nxt_s = R_IDLE;
        end else begin
          rx_state_nxt_s = R_DROP;
        end
      end
      default: rx_state_nxt_s = R_IDLE;
    endcase
  end

  // RX state, write register, byte counter and drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_r     <= R_IDLE;
      fifo_wr_en_r   <= 1'b0;
      fifo_wr_data_r <= 8'h00;
      push_r         <= 1'b0;
      len_r          <= {LEN_W{1'b0}};
      wr_cnt_r       <= {LEN_W{1'b0}};
      drop_cnt_r     <= 16'h0000;
    end else begin
      rx_state_r   <= rx_state_nxt_s;
      fifo_wr_en_r <= wr_byte_s;
      push_r       <= frame_done_s;
      if (wr_byte_s) fifo_wr_data_r <= rx_data;
      if ((rx_state_r == R_IDLE) && rx_start) begin
        len_r    <= rx_len;
        wr_cnt_r <= {LEN_W{1'b0}};
      end else if ((rx_state_r != R_IDLE) && rx_valid) begin
        wr_cnt_r <= wr_cnt_r + LEN_W'(1);
      end
      if (drop_evt_s) drop_cnt_r <= sat_inc16(drop_cnt_r);
    end
  end

  // payload FIFO occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt_r <= {LEN_W{1'b0}};
    end else begin
      case ({fifo_wr_en_r, rd_en_s})
        2'b10:   fill_cnt_r <= fill_cnt_r + LEN_W'(1);
        2'b01:   fill_cnt_r <= fill_cnt_r - LEN_W'(1);
        default: fill_cnt_r <= fill_cnt_r;
      endcase
    end
  end

  frame_len_queue #(.DEPTH(LEN_Q_DEPTH), .W(LEN_W)) u_len_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_r),
    .push_data (len_r),
    .pop       (pop_s),
    .head      (q_head_s),
    .count     (q_count_s),
    .empty     (q_empty_s)
  );

  // TX next state, queue pop and FIFO read enable
  always_comb begin
    tx_state_nxt_s = tx_state_r;
    pop_s          = 1'b0;
    rd_en_s        = 1'b0;
    case (tx_state_r)
      T_IDLE: begin
        if (!q_empty_s) tx_state_nxt_s = T_REQ;
        else            tx_state_nxt_s = T_IDLE;
      end
      T_REQ: begin
        if (tx_ack) begin
          tx_state_nxt_s = T_SEND;
          pop_s          = 1'b1;
        end else begin
          tx_state_nxt_s = T_REQ;
        end
      end
      T_SEND: begin
        rd_en_s = tx_req && (rd_cnt_r < tx_byte_num_r);
        if (rd_cnt_r == tx_byte_num_r) tx_state_nxt_s = T_IDLE;
        else                           tx_state_nxt_s = T_SEND;
      end
      default: tx_state_nxt_s = T_IDLE;
    endcase
  end

  // TX state, requested length and read counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r    <= T_IDLE;
      tx_byte_num_r <= {LEN_W{1'b0}};
      rd_cnt_r      <= {LEN_W{1'b0}};
    end else begin
      tx_state_r <= tx_state_nxt_s;
      if ((tx_state_r == T_IDLE) && !q_empty_s) tx_byte_num_r <= q_head_s;
      if (pop_s)        rd_cnt_r <= {LEN_W{1'b0}};
      else if (rd_en_s) rd_cnt_r <= rd_cnt_r + LEN_W'(1);
    end
  end

  assign fifo_wr_en   = fifo_wr_en_r;
  assign fifo_wr_data = fifo_wr_data_r;
  assign fifo_rd_en   = rd_en_s;
  assign tx_start_en  = (tx_state_r == T_REQ);
  assign tx_byte_num  = tx_byte_num_r;
  assign frame_pend   = q_count_s;
  assign drop_cnt     = drop_cnt_r;

  udp_loop_fifo_ctrl_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_wr_en (fifo_wr_en_r),
    .fifo_full  (fifo_full),
    .fifo_rd_en (rd_en_s),
    .fifo_empty (fifo_empty)
  );

endmodule
